ldlt_fwd_subst: RTL and testbench

- Downstream stage of the LDLT factorisation block: consumes the packed lower-triangular factor stream plus a right-hand-side vector b, and solves L·y = b by forward substitution (L unit lower-triangular; diagonal words carry D and are not used as divisors).
- Results go to the diagonal-scaling/back-substitution stage.
- Fixed point throughout, Q(DATA_LEN−FRACTION).FRACTION, two's complement.
- One MAC per accepted word, computed on the fly as L streams in; no L storage.

---
 rtl/ldlt_pkg.sv | 49 ++++
 rtl/ldlt_fwd_subst_if.sv | 26 ++
 rtl/fxp_mac.sv | 57 +++++
 rtl/ldlt_fwd_subst.sv | 192 +++++++++++++++++++
 tb/tb_ldlt_fwd_subst.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ldlt_pkg.sv
// Shared definitions for the LDLT factorisation and solve blocks.
//   - Default word/fraction widths, matrix size helpers.
//   - FSM state encoding of the forward-substitution stage.
//   - Saturation bounds for the default word width.
//   - Fixed-point multiply with arithmetic right shift (width generic up to FXP_MAX_LEN).
package ldlt_pkg;

    localparam int unsigned DATA_LEN_DEF = 32;
    localparam int unsigned FRACTION_DEF = 16;

    // Widest operand the shared multiply-shift accepts; callers sign-extend into it.
    localparam int unsigned FXP_MAX_LEN  = 64;

    localparam logic signed [DATA_LEN_DEF-1:0] SAT_MAX = {1'b0, {(DATA_LEN_DEF-1){1'b1}}};
    localparam logic signed [DATA_LEN_DEF-1:0] SAT_MIN = {1'b1, {(DATA_LEN_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StLoadB,
        StRun,
        StOut
    } ldlt_state_e;

    // Matrix dimension: six states per node.
    function automatic int unsigned mat_dim(input int unsigned node_num);
        return 6 * node_num;
    endfunction

    // Word count of a packed lower triangle including the diagonal.
    function automatic int unsigned tri_size(input int unsigned n);
        return n * (n + 1) / 2;
    endfunction

    // Full-width signed product followed by an arithmetic shift (truncates toward -inf).
    function automatic logic signed [2*FXP_MAX_LEN-1:0] fxp_mul_shift(
        input logic signed [FXP_MAX_LEN-1:0] a,
        input logic signed [FXP_MAX_LEN-1:0] b,
        input int unsigned                   frac
    );
        logic signed [2*FXP_MAX_LEN-1:0] a_w;
        logic signed [2*FXP_MAX_LEN-1:0] b_w;
        logic signed [2*FXP_MAX_LEN-1:0] p;
        a_w = $signed({{FXP_MAX_LEN{a[FXP_MAX_LEN-1]}}, a});
        b_w = $signed({{FXP_MAX_LEN{b[FXP_MAX_LEN-1]}}, b});
        p   = a_w * b_w;
        return p >>> frac;
    endfunction

endpackage

// File: rtl/ldlt_fwd_subst_if.sv
// Frame stream interface of the forward-substitution stage.
//   i_start/i_valid/i_data : frame input (b vector then packed L), driven by master.
//   o_valid/o_data         : y vector stream, o_busy frame in flight, o_sat saturation flag.
interface ldlt_fwd_subst_if
    import ldlt_pkg::*;
#(
    parameter int unsigned DATA_LEN = DATA_LEN_DEF
);
    logic                       i_start;
    logic                       i_valid;
    logic signed [DATA_LEN-1:0] i_data;
    logic                       o_valid;
    logic signed [DATA_LEN-1:0] o_data;
    logic                       o_busy;
    logic                       o_sat;

    modport master (
        output i_start, i_valid, i_data,
        input  o_valid, o_data, o_busy, o_sat
    );

    modport slave (
        input  i_start, i_valid, i_data,
        output o_valid, o_data, o_busy, o_sat
    );
endinterface

// File: rtl/fxp_mac.sv
// Fixed-point multiply-accumulate: acc += (a*b) >>> FRACTION, synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear accumulator (wins over en)
//   en       : accumulate a*b this cycle
//   a, b     : signed DATA_LEN operands
//   acc      : signed 2*DATA_LEN+4 accumulator
module fxp_mac
    import ldlt_pkg::*;
#(
    parameter int unsigned DATA_LEN = DATA_LEN_DEF,
    parameter int unsigned FRACTION = FRACTION_DEF,
    parameter int unsigned ACC_LEN  = 2 * DATA_LEN + 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic signed [DATA_LEN-1:0] a,
    input  logic signed [DATA_LEN-1:0] b,
    output logic signed [ACC_LEN-1:0]  acc
);

    localparam int unsigned WideLen = 2 * FXP_MAX_LEN;

    logic signed [FXP_MAX_LEN-1:0] a_ext;
    logic signed [FXP_MAX_LEN-1:0] b_ext;
    logic signed [WideLen-1:0]     prod;
    logic signed [WideLen-1:0]     acc_ext;
    logic signed [ACC_LEN-1:0]     acc_d;
    logic signed [ACC_LEN-1:0]     acc_q;

    assign a_ext   = $signed({{(FXP_MAX_LEN-DATA_LEN){a[DATA_LEN-1]}}, a});
    assign b_ext   = $signed({{(FXP_MAX_LEN-DATA_LEN){b[DATA_LEN-1]}}, b});
    assign prod    = fxp_mul_shift(a_ext, b_ext, FRACTION);
    assign acc_ext = $signed({{(WideLen-ACC_LEN){acc_q[ACC_LEN-1]}}, acc_q});

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            // Shifted product fits in 2*DATA_LEN bits, so truncating the sum is exact.
            acc_d = ACC_LEN'(acc_ext + prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ldlt_fwd_subst.sv
// Forward substitution L*y = b on a streamed unit-lower-triangular factor.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of ldlt_fwd_subst_if
//              in : i_start (frame start), i_valid/i_data (b[0..N-1] then L row-major)
//              out: o_valid/o_data (y[0..N-1]), o_busy, o_sat (sticky per frame)
// One MAC per accepted off-diagonal word; the diagonal word closes the row and
// produces y[r] = sat(b[r] - acc). L is never stored.
module ldlt_fwd_subst
    import ldlt_pkg::*;
#(
    parameter int unsigned DATA_LEN = DATA_LEN_DEF,
    parameter int unsigned NODE_NUM = 1,
    parameter int unsigned FRACTION = FRACTION_DEF
) (
    input logic               clk,
    input logic               rst,
    ldlt_fwd_subst_if.slave   bus
);

    localparam int unsigned N       = mat_dim(NODE_NUM);
    localparam int unsigned L_SIZE  = tri_size(N);
    localparam int unsigned AccLen  = 2 * DATA_LEN + 4;
    localparam int unsigned DiffLen = AccLen + 1;
    localparam int unsigned IdxW    = $clog2(N + 1);
    localparam int unsigned CntW    = $clog2(L_SIZE + 1);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
    localparam logic [IdxW-1:0] NIdx    = IdxW'(N);
    localparam logic [CntW-1:0] LCnt    = CntW'(L_SIZE);

    localparam logic signed [DATA_LEN-1:0] SatMax = {1'b0, {(DATA_LEN-1){1'b1}}};
    localparam logic signed [DATA_LEN-1:0] SatMin = {1'b1, {(DATA_LEN-1){1'b0}}};
    localparam logic signed [DiffLen-1:0]  DiffMax = {{(DiffLen-DATA_LEN){1'b0}}, SatMax};
    localparam logic signed [DiffLen-1:0]  DiffMin = {{(DiffLen-DATA_LEN){1'b1}}, SatMin};

    ldlt_state_e state_q, state_d;

    logic [IdxW-1:0] k_q, k_d;              // b load index
    logic [IdxW-1:0] r_q, r_d;              // current L row
    logic [IdxW-1:0] c_q, c_d;              // current L column
    logic [CntW-1:0] l_cnt_q, l_cnt_d;      // accepted L words
    logic [IdxW-1:0] out_idx_q, out_idx_d;  // next y to present

    logic signed [DATA_LEN-1:0] b_q [N];
    logic signed [DATA_LEN-1:0] b_d [N];
    logic signed [DATA_LEN-1:0] y_q [N];
    logic signed [DATA_LEN-1:0] y_d [N];

    logic signed [DATA_LEN-1:0] o_data_q, o_data_d;
    logic                       sat_q, sat_d;

    logic                       mac_en;
    logic                       mac_clr;
    logic signed [AccLen-1:0]   acc;
    logic signed [DATA_LEN-1:0] y_cur;
    logic signed [DATA_LEN-1:0] b_cur;
    logic signed [DiffLen-1:0]  diff;
    logic signed [DATA_LEN-1:0] y_new;
    logic                       y_sat;

    // y[c] of an earlier row is already registered when the current row streams in.
    assign y_cur = y_q[c_q];
    assign b_cur = b_q[r_q];

    fxp_mac #(
        .DATA_LEN (DATA_LEN),
        .FRACTION (FRACTION),
        .ACC_LEN  (AccLen)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (bus.i_data),
        .b   (y_cur),
        .acc (acc)
    );

    always_comb begin
        diff  = $signed({{(DiffLen-DATA_LEN){b_cur[DATA_LEN-1]}}, b_cur})
              - $signed({acc[AccLen-1], acc});
        y_new = SatMax;
        y_sat = 1'b1;
        if (diff > DiffMax) begin
            y_new = SatMax;
        end else if (diff < DiffMin) begin
            y_new = SatMin;
        end else begin
            y_new = diff[DATA_LEN-1:0];
            y_sat = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        r_d       = r_q;
        c_d       = c_q;
        l_cnt_d   = l_cnt_q;
        out_idx_d = out_idx_q;
        b_d       = b_q;
        y_d       = y_q;
        o_data_d  = o_data_q;
        sat_d     = sat_q;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d = StLoadB;
                    k_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    l_cnt_d = '0;
                    sat_d   = 1'b0;
                    mac_clr = 1'b1;
                end
            end
            StLoadB: begin
                if (bus.i_valid) begin
                    b_d[k_q] = bus.i_data;
                    k_d      = k_q + 1'b1;
                    if (k_q == LastIdx) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (l_cnt_q == LCnt) begin
                    // One settle cycle after the last diagonal, then start streaming y.
                    state_d   = StOut;
                    o_data_d  = y_q[0];
                    out_idx_d = IdxW'(1);
                end else if (bus.i_valid) begin
                    l_cnt_d = l_cnt_q + 1'b1;
                    if (c_q == r_q) begin
                        y_d[r_q] = y_new;
                        sat_d    = sat_q | y_sat;
                        mac_clr  = 1'b1;
                        r_d      = r_q + 1'b1;
                        c_d      = '0;
                    end else begin
                        mac_en = 1'b1;
                        c_d    = c_q + 1'b1;
                    end
                end
            end
            StOut: begin
                if (out_idx_q == NIdx) begin
                    state_d = StIdle;
                end else begin
                    o_data_d  = y_q[out_idx_q];
                    out_idx_d = out_idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            l_cnt_q   <= '0;
            out_idx_q <= '0;
            b_q       <= '{default: '0};
            y_q       <= '{default: '0};
            o_data_q  <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            r_q       <= r_d;
            c_q       <= c_d;
            l_cnt_q   <= l_cnt_d;
            out_idx_q <= out_idx_d;
            b_q       <= b_d;
            y_q       <= y_d;
            o_data_q  <= o_data_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.o_valid = (state_q == StOut);
    assign bus.o_busy  = (state_q != StIdle);
    assign bus.o_data  = o_data_q;
    assign bus.o_sat   = sat_q;

endmodule

// File: tb/tb_ldlt_fwd_subst.sv
module tb_ldlt_fwd_subst;

    localparam int DL = 32;
    localparam int FR = 16;
    localparam int N  = 6;
    localparam int LS = N * (N + 1) / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ldlt_fwd_subst_if #(.DATA_LEN(DL)) bus ();

    ldlt_fwd_subst #(
        .DATA_LEN (DL),
        .NODE_NUM (1),
        .FRACTION (FR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    bit exp_sat;
    int b_v[N];
    int l_v[LS];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Bit-accurate reference: pushes y[0..N-1] and the frame's saturation flag.
    function automatic void model();
        int y[N];
        int idx = 0;
        exp_sat = 1'b0;
        for (int r = 0; r < N; r++) begin
            longint acc = 0;
            longint d;
            for (int c = 0; c < r; c++) begin
                acc += (longint'(l_v[idx]) * longint'(y[c])) >>> FR;
                idx++;
            end
            idx++;
            d = longint'(b_v[r]) - acc;
            if (d > 64'sd2147483647) begin
                y[r] = 32'h7FFFFFFF;
                exp_sat = 1'b1;
            end else if (d < -64'sd2147483648) begin
                y[r] = 32'h80000000;
                exp_sat = 1'b1;
            end else begin
                y[r] = int'(d);
            end
            exp_q.push_back(y[r]);
        end
    endfunction

    task automatic set_identity();
        for (int e = 0; e < LS; e++) l_v[e] = 0;
        for (int r = 0; r < N; r++) l_v[r * (r + 1) / 2 + r] = 65536;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
    endtask

    task automatic drive_word(input int w, input int gap_pct, input bit st);
        int g = 0;
        while (g < 8 && $urandom_range(0, 99) < gap_pct) begin
            bus.i_valid = 1'b0;
            bus.i_data  = $urandom;
            @(posedge clk);
            #1 g++;
        end
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        bus.i_start = st;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
    endtask

    task automatic run_frame(input string name, input int gap_pct, input bit start_in_run,
                             input bit start_in_out);
        int lat = 0;
        int got = 0;
        model();
        pulse_start();
        check({name, "_busy"}, bus.o_busy, 1);
        for (int k = 0; k < N; k++) drive_word(b_v[k], gap_pct, 1'b0);
        for (int e = 0; e < LS; e++) drive_word(l_v[e], gap_pct, start_in_run && e == 8);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.o_valid) break;
            lat++;
        end
        check({name, "_latency"}, lat, 1);
        for (int t = 0; t < N + 4; t++) begin
            if (!bus.o_valid) break;
            if (exp_q.size() == 0) begin
                check({name, "_extra_y"}, bus.o_data, 0);
            end else begin
                check({name, "_y"}, bus.o_data, exp_q.pop_front());
            end
            check({name, "_sat"}, bus.o_sat, exp_sat);
            got++;
            bus.i_start = (start_in_out && got == 2);
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        check({name, "_valid_cycles"}, got, N);
        check({name, "_busy_end"}, bus.o_busy, 0);
        check({name, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 check({name, "_idle_after"}, bus.o_valid, 0);
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;

        #1 rst = 1'b1;
        #2;
        check("rst_valid", bus.o_valid, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_sat", bus.o_sat, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Stray words in IDLE must be ignored.
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h1234;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;

        set_identity();
        for (int k = 0; k < N; k++) b_v[k] = (k + 1) << 16;
        run_frame("ident", 0, 1'b0, 1'b0);

        set_identity();
        for (int k = 0; k < N; k++) b_v[k] = 0;
        l_v[1] = 32768;
        b_v[0] = 131072;
        b_v[1] = 196608;
        run_frame("couple", 0, 1'b0, 1'b0);

        for (int e = 0; e < LS; e++) l_v[e] = int'($urandom_range(0, 131070)) - 65535;
        for (int k = 0; k < N; k++) b_v[k] = int'($urandom_range(0, 2097152)) - 1048576;
        run_frame("dense", 0, 1'b0, 1'b0);
        run_frame("dense_gap", 45, 1'b0, 1'b0);
        run_frame("dense_pulse", 0, 1'b1, 1'b1);

        set_identity();
        for (int k = 0; k < N; k++) b_v[k] = 0;
        b_v[0] = 32'h7FFF0000;
        l_v[1] = 32'h80000000;
        run_frame("satur", 0, 1'b0, 1'b0);
        set_identity();
        for (int k = 0; k < N; k++) b_v[k] = (k + 1) << 16;
        run_frame("clean", 0, 1'b0, 1'b0);

        // Abort in RUN at row 3 (words for rows 0..2 plus L[3][0] accepted).
        pulse_start();
        for (int k = 0; k < N; k++) drive_word(b_v[k], 0, 1'b0);
        for (int e = 0; e < 7; e++) drive_word(l_v[e], 0, 1'b0);
        check("pre_rst_busy", bus.o_busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", bus.o_valid, 0);
        check("midrst_busy", bus.o_busy, 0);
        check("midrst_data", bus.o_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_frame("after_rst", 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
